// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared constants, FSM states and sign helper for the multi-cycle EX units
//
// Contents:
//   DEFAULT_WIDTH  default operand width
//   CNT_W          step-counter width for DEFAULT_WIDTH
//   MAX_W          widest value cond_neg handles (covers a 2*64-bit product)
//   state_t        IDLE / RUN / DONE
//   cond_neg       two's-complement negate when en=1, shared with the divider
package mult_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int CNT_W         = $clog2(DEFAULT_WIDTH);
  localparam int MAX_W         = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Callers zero-extend into MAX_W and size-cast the result back, so one
  // helper serves both the W-bit operand magnitudes and the 2W-bit product.
  function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] x, input logic en);
    return en ? (~x + MAX_W'(1)) : x;
  endfunction

endpackage

// File: rtl/seq_mult_if.sv
// rtl/seq_mult_if.sv - start/busy/ready handshake bundle of the sequential multiplier
//
// Signals (WIDTH parameter = operand width):
//   a, b, sign, start   requester -> multiplier (sampled on start)
//   hi, lo, busy, ready multiplier -> requester (all registered)
// Modports: master = requester (EX stage), slave = multiplier.
interface seq_mult_if
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sign;
  logic             start;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             ready;

  modport master (output a, b, sign, start, input hi, lo, busy, ready);
  modport slave  (input a, b, sign, start, output hi, lo, busy, ready);

endinterface

// File: rtl/mult_step.sv
// rtl/mult_step.sv - one combinational radix-2 shift-add iteration
//
// Ports (WIDTH = operand width):
//   acc      in   WIDTH+1  running partial-product high part
//   mq       in   WIDTH    multiplier bits still to consume (LSB first) / low product bits
//   mcand    in   WIDTH    multiplicand magnitude
//   acc_nxt  out  WIDTH+1  acc after add-and-shift
//   mq_nxt   out  WIDTH    mq after add-and-shift
module mult_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] mq,
  input  logic [WIDTH-1:0] mcand,
  output logic [WIDTH:0]   acc_nxt,
  output logic [WIDTH-1:0] mq_nxt
);

  logic [WIDTH:0] sum;

  // acc stays below 2^WIDTH after every shift, so acc + mcand fits in WIDTH+1 bits.
  assign sum = mq[0] ? (acc + {1'b0, mcand}) : acc;

  // {sum, mq} treated as one 2W+1-bit value shifted right by one.
  assign acc_nxt = {1'b0, sum[WIDTH:1]};
  assign mq_nxt  = {sum[0], mq[WIDTH-1:1]};

endmodule

// File: rtl/seq_mult.sv
// rtl/seq_mult.sv - iterative shift-add multiplier, signed/unsigned, 2W-bit product on hi/lo
//
// Ports:
//   clk   in  clock, rising edge
//   rst   in  asynchronous active-high reset
//   bus   seq_mult_if.slave: a, b, sign, start in; hi, lo, busy, ready out
// Configuration macro: EARLY_TERM_EN - stop as soon as the remaining multiplier
//   bits are zero and align the product with one barrel shift.
module seq_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic       clk,
  input  logic       rst,
  seq_mult_if.slave  bus
);

  localparam int STEP_W = $clog2(WIDTH);
  localparam int PW     = 2 * WIDTH;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  mcand;
  logic [WIDTH-1:0]  mq, mq_nxt;
  logic [WIDTH:0]    acc, acc_nxt;
  logic [STEP_W-1:0] cnt;
  logic              neg;
  logic              last_step;
  logic [WIDTH-1:0]  a_mag, b_mag;
  logic [PW-1:0]     prod, prod_fix;
  logic [WIDTH-1:0]  hi_q, lo_q;
  logic              busy_q, ready_q;

  assign a_mag = WIDTH'(cond_neg(MAX_W'(bus.a), bus.sign & bus.a[WIDTH-1]));
  assign b_mag = WIDTH'(cond_neg(MAX_W'(bus.b), bus.sign & bus.b[WIDTH-1]));

  mult_step #(.WIDTH(WIDTH)) u_step (
    .acc     (acc),
    .mq      (mq),
    .mcand   (mcand),
    .acc_nxt (acc_nxt),
    .mq_nxt  (mq_nxt)
  );

`ifdef EARLY_TERM_EN
  // After step cnt, the low WIDTH-1-cnt bits of mq_nxt are still unconsumed
  // multiplier bits; once they are zero the remaining steps would only shift.
  logic [STEP_W:0]  step_no;
  logic [WIDTH-1:0] keep_mask;
  assign step_no   = {1'b0, cnt} + 1'b1;
  assign keep_mask = {WIDTH{1'b1}} >> step_no;
  assign last_step = ((mq_nxt & keep_mask) == '0);
  // Remaining shift count is WIDTH-1-cnt, which is ~cnt for power-of-two WIDTH.
  assign prod      = PW'({acc_nxt, mq_nxt} >> ~cnt);
`else
  assign last_step = (cnt == STEP_W'(WIDTH - 1));
  assign prod      = {acc_nxt[WIDTH-1:0], mq_nxt};
`endif

  assign prod_fix = PW'(cond_neg(MAX_W'(prod), neg));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (bus.start) state_nxt = RUN;
               else if (last_step) state_nxt = DONE;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      mq      <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      if (bus.start) begin
        // Restart from any state; an in-flight operation is simply dropped.
        mcand  <= a_mag;
        mq     <= b_mag;
        acc    <= '0;
        cnt    <= '0;
        neg    <= bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        busy_q <= 1'b1;
      end else if (state == RUN) begin
        acc <= acc_nxt;
        mq  <= mq_nxt;
        cnt <= cnt + 1'b1;
        if (last_step) begin
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          hi_q    <= prod_fix[PW-1:WIDTH];
          lo_q    <= prod_fix[WIDTH-1:0];
        end
      end
    end
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.busy  = busy_q;
  assign bus.ready = ready_q;

endmodule

// File: tb/tb_seq_mult.sv
// tb/tb_seq_mult.sv - self-checking bench for seq_mult (vector table + scoreboard)
module tb_seq_mult;

  localparam int W = 32;
  localparam int NV = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_mult_if #(.WIDTH(W)) bus ();

  seq_mult #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sign;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           start_cyc;
    int           lat;
  } exp_t;

  exp_t sb[$];
  vec_t vt[NV];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_ready = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic signed [63:0] xa, xb;
    if (s) begin
      xa = {{32{a[31]}}, a};
      xb = {{32{b[31]}}, b};
      return xa * xb;
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic int exp_lat(input logic [W-1:0] b, input logic s);
`ifdef EARLY_TERM_EN
    logic [W-1:0] m;
    int l;
    m = (s && b[W-1]) ? (~b + 32'd1) : b;
    l = 1;
    for (int i = 0; i < W; i++) if (m[i]) l = i + 1;
    return l;
`else
    if (s === 1'bx) return 0;
    return W;
`endif
  endfunction

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.ready === 1'b1) begin
        n_ready++;
        check("busy_at_ready", {63'b0, bus.busy}, 64'd0);
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_ready: got ready=1 expected no ready at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          check("hi", {32'b0, bus.hi}, {32'b0, e.hi});
          check("lo", {32'b0, bus.lo}, {32'b0, e.lo});
          check("latency", 64'(cyc - e.start_cyc - 1), 64'(e.lat));
        end
      end
    end
  end

  task automatic do_start(input vec_t v);
    exp_t e;
    @(posedge clk);
    #1;
    bus.a     = v.a;
    bus.b     = v.b;
    bus.sign  = v.sign;
    bus.start = 1'b1;
    e.hi = v.hi;
    e.lo = v.lo;
    e.start_cyc = cyc;
    e.lat = exp_lat(v.b, v.sign);
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    // Operands must be ignored while busy.
    bus.a     = $urandom;
    bus.b     = $urandom;
    bus.sign  = $urandom_range(0, 1);
    check("busy_after_start", {63'b0, bus.busy}, 64'd1);
  endtask

  task automatic wait_idle(input int limit);
    int k = 0;
    while (sb.size() != 0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
  endtask

  function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    vec_t v;
    v.a = a;
    v.b = b;
    v.sign = s;
    {v.hi, v.lo} = ref_prod(a, b, s);
    return v;
  endfunction

  initial begin
    vec_t v;
    int r0;
    bus.a = '0;
    bus.b = '0;
    bus.sign = 1'b0;
    bus.start = 1'b0;

    vt[0]  = '{32'd7,         32'd6,         1'b0, 32'h0000_0000, 32'd42};
    vt[1]  = '{32'hFFFF_FFFD, 32'd5,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vt[2]  = '{32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000};
    vt[3]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001};
    vt[4]  = '{32'h1234_5678, 32'd1,         1'b0, 32'h0000_0000, 32'h1234_5678};
    vt[5]  = '{32'hDEAD_BEEF, 32'h100,       1'b0, 32'h0000_00DE, 32'hADBE_EF00};
    vt[6]  = '{32'hFFFF_FFF9, 32'd0,         1'b1, 32'h0000_0000, 32'h0000_0000};
    vt[7]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h8000_0000};
    for (int i = 8; i < NV; i++) vt[i] = mk($urandom, $urandom, 1'(i % 2));

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  {63'b0, bus.busy},  64'd0);
    check("rst_ready", {63'b0, bus.ready}, 64'd0);
    check("rst_hi",    {32'b0, bus.hi},    64'd0);
    check("rst_lo",    {32'b0, bus.lo},    64'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      do_start(vt[i]);
      wait_idle(100);
    end

    // Restart while busy: only the second operation may produce a result.
    r0 = n_ready;
    do_start(mk(32'd2, 32'd3, 1'b0));
    repeat (8) @(posedge clk);
    if (sb.size() != 0) begin
      void'(sb.pop_back());
      r0 = r0 - 1;
    end
    do_start('{32'd4, 32'd5, 1'b0, 32'd0, 32'd20});
    wait_idle(100);
    repeat (5) @(negedge clk);
    check("restart_ready_count", 64'(n_ready - r0), 64'd2);

    // Asynchronous reset mid-operation.
    do_start(mk(32'h1234, 32'h5678, 1'b0));
    repeat (13) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_busy",  {63'b0, bus.busy},  64'd0);
    check("midrst_ready", {63'b0, bus.ready}, 64'd0);
    check("midrst_hi",    {32'b0, bus.hi},    64'd0);
    check("midrst_lo",    {32'b0, bus.lo},    64'd0);
    sb.delete();
    r0 = n_ready;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("midrst_no_ready", 64'(n_ready), 64'(r0));

    // Normal operation after reset.
    v = mk(32'hFFFF_0000, 32'h0001_0001, 1'b1);
    do_start(v);
    wait_idle(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
